// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the ALU logic units.
// Imported by the serial unit and the per-bit logic cell.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_logic.sv
// One-bit logic cell: y = op(a, b).
// Purely combinational so parallel units can reuse it per lane.
module alu_bit_logic
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  // Decode the opcode into the selected bitwise function
  always_comb begin
    y = 1'b0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_logic_unit.sv
// Bit-serial logic unit: one result bit per cycle, LSB first,
// result held with zero/parity flags until the consumer takes it.
module alu_serial_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_parity
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;
  logic             bit_y;

  // Operands shift right so the current bit is always at index 0
  alu_bit_logic u_bit (
    .op (op_q),
    .a  (a_q[0]),
    .b  (b_q[0]),
    .y  (bit_y)
  );

  // Next-state and datapath update for the IDLE/SHIFT/HOLD sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    zero_d  = zero_q;
    par_d   = par_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SHIFT;
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          cnt_d   = '0;
          sh_d    = '0;
          zero_d  = 1'b1;
          par_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        sh_d   = {bit_y, sh_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        zero_d = zero_q & ~bit_y;
        par_d  = par_q ^ bit_y;
        if (cnt_q == LAST) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign res_valid  = (state_q == S_HOLD);
  assign res_data   = res_valid ? sh_q : '0;
  assign res_zero   = res_valid & zero_q;
  assign res_parity = res_valid & par_q;

endmodule

// File: tb/tb_alu_serial_logic_unit.sv
// Directed bench for the serial logic unit (WIDTH 4 and 8).
// Expected results are queued at accept and popped at handshake.
module tb_alu_serial_logic_unit;

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b, res_data;
  logic       res_valid, res_ready, res_zero, res_parity;

  logic       cmd_valid8, cmd_ready8;
  logic [1:0] cmd_op8;
  logic [7:0] cmd_a8, cmd_b8, res_data8;
  logic       res_valid8, res_ready8, res_zero8, res_parity8;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_serial_logic_unit #(.WIDTH(4)) u4 (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_parity (res_parity)
  );

  alu_serial_logic_unit #(.WIDTH(8)) u8 (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid8),
    .cmd_ready  (cmd_ready8),
    .cmd_op     (cmd_op8),
    .cmd_a      (cmd_a8),
    .cmd_b      (cmd_b8),
    .res_valid  (res_valid8),
    .res_ready  (res_ready8),
    .res_data   (res_data8),
    .res_zero   (res_zero8),
    .res_parity (res_parity8)
  );

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] b,
                                 input int w);
    exp_t e;
    e = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00: e.data[i] = a[i] & b[i];
        2'b01: e.data[i] = a[i] | b[i];
        2'b10: e.data[i] = a[i] ^ b[i];
        default: e.data[i] = a[i] ~^ b[i];
      endcase
    end
    e.zero = (e.data == 8'h00);
    e.par  = ^e.data;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one command on the WIDTH=4 unit and drain its result.
  // keep: cmd_valid stays high afterwards carrying the next command.
  task automatic run4(input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input int hold_wait,
                      input bit keep, input logic [1:0] nop,
                      input logic [3:0] na, input logic [3:0] nb,
                      input int exp_gap);
    int   edges;
    exp_t e;
    logic [3:0] held;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
    chk("cmd_ready_idle", 16'(cmd_ready), 16'd1);
    sb.push_back(model(op, 8'(a), 8'(b), 4));
    if (exp_gap > 0) chk("throughput", 16'(cyc - last_acc), 16'(exp_gap));
    last_acc = cyc;
    step();
    edges = 1;
    if (keep) begin
      cmd_op = nop;
      cmd_a  = na;
      cmd_b  = nb;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!res_valid && edges < 30) begin
      if (cmd_ready !== 1'b0 || res_data !== 4'h0 ||
          res_parity !== 1'b0 || res_zero !== 1'b0)
        chk("shift_outputs",
            16'({cmd_ready, res_zero, res_parity, res_data}), 16'd0);
      step();
      edges++;
    end
    chk("latency_w4", 16'(edges), 16'd5);
    held = res_data;
    for (int k = 0; k < hold_wait; k++) begin
      chk("hold_stable", 16'(res_data), 16'(held));
      chk("hold_cmd_ready", 16'(cmd_ready), 16'd0);
      chk("hold_valid", 16'(res_valid), 16'd1);
      step();
    end
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk("res_data", 16'(res_data), 16'(e.data[3:0]));
      chk("res_zero", 16'(res_zero), 16'(e.zero));
      chk("res_parity", 16'(res_parity), 16'(e.par));
    end
    step();
    chk("post_hs_valid", 16'(res_valid), 16'd0);
    chk("post_hs_ready", 16'(cmd_ready), 16'd1);
    chk("post_hs_data", 16'(res_data), 16'd0);
  endtask

  initial begin
    int   edges;
    exp_t e;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0;
    cmd_valid8 = 1'b0; cmd_op8 = '0; cmd_a8 = '0; cmd_b8 = '0;
    res_ready8 = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("rst_res_valid", 16'(res_valid), 16'd0);
    chk("rst_res_data", 16'(res_data), 16'd0);
    chk("rst_res_zero", 16'(res_zero), 16'd0);
    chk("rst_res_parity", 16'(res_parity), 16'd0);
    rst = 1'b0;
    step();

    res_ready = 1'b1;
    run4(2'b00, 4'b1011, 4'b0110, 0, 0, 0, 0, 0, 0);
    step();
    run4(2'b11, 4'b1010, 4'b0101, 0, 0, 0, 0, 0, 0);
    res_ready = 1'b0;
    run4(2'b10, 4'b1111, 4'b0001, 3, 0, 0, 0, 0, 0);
    res_ready = 1'b0;
    run4(2'b01, 4'b1000, 4'b0001, 0, 1, 2'b00, 4'b1111, 4'b1111, 0);
    run4(2'b00, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 6);

    // abort mid-SHIFT by reset
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_a = 4'b1111; cmd_b = 4'b0000;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("abort_outputs",
        16'({res_valid, res_zero, res_parity, res_data}), 16'd0);
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_valid", 16'(res_valid), 16'd0);
      step();
    end

    // WIDTH=8 latency and result
    cmd_valid8 = 1'b1;
    cmd_op8 = 2'b10; cmd_a8 = 8'hA5; cmd_b8 = 8'hFF;
    chk("w8_cmd_ready", 16'(cmd_ready8), 16'd1);
    sb.push_back(model(2'b10, 8'hA5, 8'hFF, 8));
    step();
    cmd_valid8 = 1'b0;
    edges = 1;
    while (!res_valid8 && edges < 30) begin
      step();
      edges++;
    end
    chk("latency_w8", 16'(edges), 16'd9);
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk("w8_res_data", 16'(res_data8), 16'(e.data));
      chk("w8_res_zero", 16'(res_zero8), 16'(e.zero));
      chk("w8_res_parity", 16'(res_parity8), 16'(e.par));
    end
    step();
    chk("w8_post_hs", 16'({res_valid8, cmd_ready8}), 16'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_serial_logic_unit.md
ALU_SERIAL_LOGIC_UNIT -- requirements
Module: alu_serial_logic_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 cmd_a  input  WIDTH  operand A.
REQ-008 cmd_b  input  WIDTH  operand B.
REQ-009 res_valid  output  1  result held and valid.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_data  output  WIDTH  bitwise result.
REQ-012 res_zero  output  1  res_data is all zeros.
REQ-013 res_parity  output  1  XOR-reduction of res_data.

Function
REQ-014 The block SHALL implement three states: IDLE, SHIFT, HOLD.
REQ-015 IDLE: cmd_ready=1; a command transfers when cmd_valid and cmd_ready are both high on a clock edge.
REQ-016 On transfer, the block SHALL latch cmd_op, cmd_a and cmd_b, clear the bit counter and the result shift register, and enter SHIFT.
REQ-017 SHIFT: one result bit per cycle, LSB first, result[i] = op(a[i], b[i]); the result shifts in from the MSB end.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; the cycle that computes bit WIDTH-1 SHALL transition to HOLD.
REQ-019 Latency: res_valid SHALL rise exactly WIDTH+1 edges after the accepting edge.
REQ-020 SHIFT and HOLD: cmd_ready=0; cmd_valid SHALL be ignored.
REQ-021 The block SHALL accumulate zero and parity running flags during SHIFT.
REQ-022 HOLD: res_valid=1.
REQ-023 In HOLD, res_data, res_zero and res_parity SHALL remain stable until the handshake.
REQ-024 HOLD -> IDLE on the edge where res_ready=1.
REQ-025 res_ready high before HOLD SHALL have no effect.
REQ-026 There SHALL be no command/result overlap: a new command is accepted no earlier than the cycle after the result handshake, with cmd_ready=1 in that IDLE cycle.
REQ-027 Throughput: one command per WIDTH+2 cycles when res_ready is held high.
REQ-028 Outside HOLD, res_data, res_zero and res_parity SHALL be 0.
REQ-029 All outputs SHALL be driven from registers or from state decode only; there is no combinational path from inputs to outputs.

Reset
REQ-030 While rst=1 at an edge: state=IDLE, counter=0, shift register=0, latched operands=0.
REQ-031 Reset values of outputs: cmd_ready=1 after the first reset edge, res_valid=0, res_data=0, res_zero=0, res_parity=0.
REQ-032 Reset asserted mid-SHIFT or mid-HOLD SHALL abort the operation and discard any partial or held result; no res_valid follows.
REQ-033 Reset SHALL take priority over any simultaneous cmd or res handshake.

Structure
REQ-034 The opcode encodings (OP_AND, OP_OR, OP_XOR, OP_XNOR) and state encodings SHALL live in the shared package alu_pkg.
REQ-035 The per-bit function SHALL be a sub-module alu_bit_logic (inputs op, a, b; output y), combinational and reusable by the parallel logic units.
REQ-036 The bit counter width SHALL be $clog2(WIDTH)+1.

Verification
REQ-037 Scenario: WIDTH=4, AND a=1011 b=0110, res_ready=1 -> res_data=0010, zero=0, parity=1, res_valid 5 edges after accept.
REQ-038 Scenario: XNOR a=1010 b=0101 -> res_data=0000, zero=1, parity=0.
REQ-039 Scenario: XOR a=1111 b=0001 with res_ready low for 3 cycles in HOLD -> res_data=1110 stable all 3 cycles; cmd_ready=0 throughout; IDLE follows the handshake.
REQ-040 Scenario: OR a=1000 b=0001 issued back-to-back with AND a=1111 b=1111, cmd_valid held high -> second command accepted in the IDLE cycle after the first handshake; results 1001 then 1111, parity 0 then 0.
REQ-041 Scenario: accept OR a=1111 b=0000, assert rst on the 2nd SHIFT cycle -> res_valid never rises; cmd_ready=1 the cycle after reset deasserts; all outputs 0.
REQ-042 Scenario: WIDTH=8, XOR a=0xA5 b=0xFF -> res_data=0x5A, parity=0, res_valid 9 edges after accept.
